// File: rtl/runner_pkg.sv
// -----------------------------------------------------------------------------
// runner_pkg
// Constants and types shared by the slot runner, the painter and the render
// scheduler.
//   RENDER_SLOTS  : number of sprite slots scheduled per frame
//   SLOT_W        : width of a slot index
//   sched_state_t : render scheduler FSM states
//   clear_slot()  : returns a slot mask with one slot bit removed
// -----------------------------------------------------------------------------
package runner_pkg;

    localparam int RENDER_SLOTS = 32;
    localparam int SLOT_W       = $clog2(RENDER_SLOTS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PICK     = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } sched_state_t;

    // Remove slot idx from a pending-slot mask once its blit has been issued.
    function automatic logic [RENDER_SLOTS-1:0] clear_slot(
        input logic [RENDER_SLOTS-1:0] mask,
        input logic [SLOT_W-1:0]       idx
    );
        logic [RENDER_SLOTS-1:0] m;
        m      = mask;
        m[idx] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/slot_picker.sv
// -----------------------------------------------------------------------------
// slot_picker
// Combinational lowest-set-bit priority encoder over the pending-slot mask.
// Slot 0 has the highest priority so sprites are drawn in ascending order and
// later slots overwrite earlier ones on screen.
// Ports:
//   mask  [RENDER_SLOTS] : pending slots
//   found                : at least one bit of mask is set
//   index [SLOT_W]       : lowest set bit position (0 when found = 0)
// -----------------------------------------------------------------------------
module slot_picker
    import runner_pkg::*;
(
    input  logic [RENDER_SLOTS-1:0] mask,
    output logic                    found,
    output logic [SLOT_W-1:0]       index
);

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        found = 1'b0;
        index = {SLOT_W{1'b0}};
        for (int i = RENDER_SLOTS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                index = SLOT_W'(i);
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/render_scheduler.sv
// -----------------------------------------------------------------------------
// render_scheduler
// Per-frame controller for the sprite blitter. On a rising edge of
// frame_start the set of occupied slots is captured, then one blit request is
// issued per captured slot in ascending slot order. A per-frame cycle budget
// aborts frames that take too long; restarting a frame while one is in
// progress also aborts it. All outputs come straight from registers.
// Ports:
//   clk_33m      : 33 MHz system clock
//   reset_n      : asynchronous active-low reset
//   frame_start  : level from screen reset, rising edge starts a frame
//   slot_valid   : per-slot occupancy from the runner
//   blit_req     : request to draw blit_slot, held until blit_ack
//   blit_slot    : slot being drawn, stable while blit_req = 1
//   blit_ack     : one-cycle pulse, blitter finished the current slot
//   blit_abort   : one-cycle pulse, cancel the in-flight blit
//   busy         : frame in progress
//   finished     : frame done, held until the next frame start
//   overrun      : last frame was aborted, held until a clean finish
//   slots_drawn  : blits acknowledged in the current/last frame
// -----------------------------------------------------------------------------
module render_scheduler
    import runner_pkg::*;
#(
    parameter int BUDGET   = 500000,
    parameter int BUDGET_W = $clog2(BUDGET + 1)
) (
    input  logic                    clk_33m,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic [RENDER_SLOTS-1:0] slot_valid,
    output logic                    blit_req,
    output logic [SLOT_W-1:0]       blit_slot,
    input  logic                    blit_ack,
    output logic                    blit_abort,
    output logic                    busy,
    output logic                    finished,
    output logic                    overrun,
    output logic [SLOT_W:0]         slots_drawn
);

    sched_state_t            state_q,       state_d;
    logic                    fs_q,          fs_d;
    logic [RENDER_SLOTS-1:0] snapshot_q,    snapshot_d;
    logic                    blit_req_q,    blit_req_d;
    logic [SLOT_W-1:0]       blit_slot_q,   blit_slot_d;
    logic                    blit_abort_q,  blit_abort_d;
    logic                    busy_q,        busy_d;
    logic                    finished_q,    finished_d;
    logic                    overrun_q,     overrun_d;
    logic [SLOT_W:0]         slots_drawn_q, slots_drawn_d;
    logic [BUDGET_W-1:0]     budget_q,      budget_d;

    logic                    start_s;
    logic                    expire_s;
    logic                    pick_found_s;
    logic [SLOT_W-1:0]       pick_idx_s;

    slot_picker u_slot_picker (
        .mask  (snapshot_q),
        .found (pick_found_s),
        .index (pick_idx_s)
    );

    // Rising edge of frame_start; the budget expires on the last allowed
    // cycle so the abort lands exactly BUDGET cycles after the start edge.
    always_comb begin
        start_s  = frame_start & ~fs_q;
        expire_s = busy_q && (budget_q == BUDGET_W'(BUDGET - 1)) && (state_q != DONE);
    end

    // Next-state and output logic. Priority: frame start, then budget
    // expiry, then normal sequencing. An ack coinciding with expiry is
    // dropped because the expiry branch never reaches the WAIT_ACK case.
    always_comb begin
        state_d       = state_q;
        fs_d          = frame_start;
        snapshot_d    = snapshot_q;
        blit_req_d    = blit_req_q;
        blit_slot_d   = blit_slot_q;
        blit_abort_d  = 1'b0;
        busy_d        = busy_q;
        finished_d    = finished_q;
        overrun_d     = overrun_q;
        slots_drawn_d = slots_drawn_q;
        budget_d      = busy_q ? (budget_q + BUDGET_W'(1)) : budget_q;

        if (start_s) begin
            if (busy_q) begin
                // Restart mid-frame: cancel whatever is in flight.
                overrun_d    = 1'b1;
                blit_abort_d = blit_req_q;
            end else begin
                overrun_d    = overrun_q;
            end
            blit_req_d    = 1'b0;
            snapshot_d    = slot_valid;
            slots_drawn_d = {(SLOT_W + 1){1'b0}};
            budget_d      = {BUDGET_W{1'b0}};
            finished_d    = 1'b0;
            busy_d        = 1'b1;
            state_d       = PICK;
        end else if (expire_s) begin
            blit_req_d   = 1'b0;
            blit_abort_d = blit_req_q;
            overrun_d    = 1'b1;
            finished_d   = 1'b1;
            busy_d       = 1'b0;
            state_d      = DONE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                PICK: begin
                    if (pick_found_s) begin
                        blit_slot_d = pick_idx_s;
                        blit_req_d  = 1'b1;
                        snapshot_d  = clear_slot(snapshot_q, pick_idx_s);
                        state_d     = WAIT_ACK;
                    end else begin
                        busy_d     = 1'b0;
                        finished_d = 1'b1;
                        overrun_d  = 1'b0;
                        state_d    = DONE;
                    end
                end
                WAIT_ACK: begin
                    if (blit_ack) begin
                        blit_req_d    = 1'b0;
                        slots_drawn_d = slots_drawn_q + (SLOT_W + 1)'(1);
                        state_d       = PICK;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d    = IDLE;
                    blit_req_d = 1'b0;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_33m or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fs_q          <= 1'b0;
            snapshot_q    <= {RENDER_SLOTS{1'b0}};
            blit_req_q    <= 1'b0;
            blit_slot_q   <= {SLOT_W{1'b0}};
            blit_abort_q  <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            overrun_q     <= 1'b0;
            slots_drawn_q <= {(SLOT_W + 1){1'b0}};
            budget_q      <= {BUDGET_W{1'b0}};
        end else begin
            state_q       <= state_d;
            fs_q          <= fs_d;
            snapshot_q    <= snapshot_d;
            blit_req_q    <= blit_req_d;
            blit_slot_q   <= blit_slot_d;
            blit_abort_q  <= blit_abort_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
            overrun_q     <= overrun_d;
            slots_drawn_q <= slots_drawn_d;
            budget_q      <= budget_d;
        end
    end

    assign blit_req    = blit_req_q;
    assign blit_slot   = blit_slot_q;
    assign blit_abort  = blit_abort_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign overrun     = overrun_q;
    assign slots_drawn = slots_drawn_q;

endmodule

// File: tb/tb_render_scheduler.sv
module tb_render_scheduler;

    localparam int BUDGET = 20;
    localparam int NS     = 32;

    localparam int EV_REQ   = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_FIN   = 2;

    typedef struct {
        int kind;
        int val;
        int ovr;
        int cyc;
    } ev_t;

    logic        clk_33m;
    logic        reset_n;
    logic        frame_start;
    logic [31:0] slot_valid;
    logic        blit_req;
    logic [4:0]  blit_slot;
    logic        blit_ack;
    logic        blit_abort;
    logic        busy;
    logic        finished;
    logic        overrun;
    logic [5:0]  slots_drawn;

    logic        resp_ack;
    logic        stray_ack;
    assign blit_ack = resp_ack | stray_ack;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  ack_delay [NS];
    ev_t exp_q [$];

    render_scheduler #(
        .BUDGET   (BUDGET),
        .BUDGET_W ($clog2(BUDGET + 1))
    ) dut (
        .clk_33m     (clk_33m),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .slot_valid  (slot_valid),
        .blit_req    (blit_req),
        .blit_slot   (blit_slot),
        .blit_ack    (blit_ack),
        .blit_abort  (blit_abort),
        .busy        (busy),
        .finished    (finished),
        .overrun     (overrun),
        .slots_drawn (slots_drawn)
    );

    initial clk_33m = 1'b0;
    always #15 clk_33m = ~clk_33m;

    always @(posedge clk_33m) cyc <= cyc + 1;

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int ovr, input int c);
        ev_t e;
        e.kind = kind; e.val = val; e.ovr = ovr; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Reference model: a frame walks the captured slots in ascending order;
    // each slot costs one pick cycle plus its ack latency. Anything that
    // would still be running at cycle BUDGET after the start edge is aborted.
    task automatic model_frame(input logic [31:0] mask, input int e0,
                               output int end_edge, output int drawn);
        int t;
        bit over;
        t = 1; drawn = 0; over = 1'b0;
        for (int s = 0; s < NS; s++) begin
            if (mask[s] && !over) begin
                if (t >= BUDGET) begin
                    over = 1'b1;
                end else begin
                    push_ev(EV_REQ, s, 0, e0 + t);
                    if (ack_delay[s] == 0 || t + ack_delay[s] >= BUDGET) begin
                        push_ev(EV_ABORT, 0, 0, e0 + BUDGET);
                        over = 1'b1;
                        t = BUDGET;
                    end else begin
                        drawn++;
                        t = t + ack_delay[s] + 1;
                    end
                end
            end
        end
        if (over || t >= BUDGET) begin
            push_ev(EV_FIN, drawn, 1, e0 + BUDGET);
            end_edge = e0 + BUDGET;
        end else begin
            push_ev(EV_FIN, drawn, 0, e0 + t);
            end_edge = e0 + t;
        end
    endtask

    task automatic raise_start(input logic [31:0] mask, output int e0);
        @(negedge clk_33m);
        slot_valid  = mask;
        frame_start = 1'b1;
        e0 = cyc + 1;
    endtask

    task automatic drop_start(input logic [31:0] mid_mask);
        @(negedge clk_33m);
        frame_start = 1'b0;
        slot_valid  = mid_mask;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_33m);
    endtask

    task automatic set_delays(input int d);
        for (int i = 0; i < NS; i++) ack_delay[i] = d;
    endtask

    task automatic pulse_stray_ack();
        @(negedge clk_33m);
        stray_ack = 1'b1;
        @(negedge clk_33m);
        stray_ack = 1'b0;
        @(negedge clk_33m);
    endtask

    task automatic check_event(input int kind, input int val, input int ovr);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: kind %0d val %0d ovr %0d at cycle %0d, none expected",
                     kind, val, ovr, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.ovr != ovr || e.cyc != cyc) begin
                failures++;
                $display("FAIL event: got kind %0d val %0d ovr %0d cycle %0d, expected kind %0d val %0d ovr %0d cycle %0d",
                         kind, val, ovr, cyc, e.kind, e.val, e.ovr, e.cyc);
            end
        end
    endtask

    // Blitter stand-in: acknowledges each new request after the latency
    // configured for its slot (0 = never).
    initial begin : responder
        bit resp_active;
        int resp_left;
        resp_ack    = 1'b0;
        resp_active = 1'b0;
        resp_left   = 0;
        forever begin
            @(negedge clk_33m);
            resp_ack = 1'b0;
            if (reset_n && blit_req) begin
                if (!resp_active) begin
                    resp_active = 1'b1;
                    resp_left   = ack_delay[blit_slot];
                end
                if (resp_left == 1) begin
                    resp_ack  = 1'b1;
                    resp_left = 0;
                end else if (resp_left > 1) begin
                    resp_left--;
                end
            end else begin
                resp_active = 1'b0;
            end
        end
    end

    // Monitor: turns DUT output activity into events and scores them.
    initial begin : monitor
        logic prev_req;
        logic prev_fin;
        logic [4:0] held_slot;
        prev_req  = 1'b0;
        prev_fin  = 1'b0;
        held_slot = 5'd0;
        forever begin
            @(negedge clk_33m);
            if (!reset_n) begin
                prev_req = 1'b0;
                prev_fin = 1'b0;
            end else begin
                if (blit_abort) check_event(EV_ABORT, 0, 0);
                if (finished && !prev_fin) check_event(EV_FIN, int'(slots_drawn), int'(overrun));
                if (blit_req && !prev_req) begin
                    check_event(EV_REQ, int'(blit_slot), 0);
                    held_slot = blit_slot;
                end else if (blit_req) begin
                    check_val("blit_slot_stable", int'(blit_slot), int'(held_slot));
                end
                prev_req = blit_req;
                prev_fin = finished;
            end
        end
    end

    initial begin : stimulus
        int e0, e1, end_edge, drawn;
        logic [31:0] m;
        reset_n     = 1'b0;
        frame_start = 1'b0;
        slot_valid  = 32'h0;
        stray_ack   = 1'b0;
        set_delays(1);

        repeat (3) @(negedge clk_33m);
        check_val("rst_blit_req",    int'(blit_req),    0);
        check_val("rst_blit_slot",   int'(blit_slot),   0);
        check_val("rst_blit_abort",  int'(blit_abort),  0);
        check_val("rst_busy",        int'(busy),        0);
        check_val("rst_finished",    int'(finished),    0);
        check_val("rst_overrun",     int'(overrun),     0);
        check_val("rst_slots_drawn", int'(slots_drawn), 0);
        reset_n = 1'b1;

        // Reset asserted while waiting for an ack that never comes.
        set_delays(0);
        raise_start(32'h0000_0010, e0);
        push_ev(EV_REQ, 4, 0, e0 + 1);
        drop_start(32'h0000_0010);
        wait_until(e0 + 5);
        check_val("waitack_busy", int'(busy), 1);
        #5 reset_n = 1'b0;
        #1;
        check_val("async_rst_req",  int'(blit_req), 0);
        check_val("async_rst_busy", int'(busy),     0);
        check_val("async_rst_slot", int'(blit_slot), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_33m);
        reset_n = 1'b1;

        // Empty frame.
        set_delays(3);
        raise_start(32'h0, e0);
        model_frame(32'h0, e0, end_edge, drawn);
        drop_start(32'h0);
        wait_until(end_edge + 2);
        check_val("empty_slots_drawn", int'(slots_drawn), 0);

        // Sparse mask with fixed ack latency.
        raise_start(32'h8000_0015, e0);
        model_frame(32'h8000_0015, e0, end_edge, drawn);
        drop_start(32'h8000_0015);
        wait_until(end_edge + 2);
        check_val("sparse_slots_drawn", int'(slots_drawn), 4);
        check_val("sparse_overrun",     int'(overrun),     0);

        // Budget expiry with no ack.
        set_delays(0);
        raise_start(32'h1, e0);
        model_frame(32'h1, e0, end_edge, drawn);
        drop_start(32'h1);
        wait_until(end_edge + 2);
        check_val("budget_req_low", int'(blit_req), 0);

        // Restart while waiting on slot 1.
        set_delays(1);
        ack_delay[0] = 2;
        ack_delay[1] = 0;
        raise_start(32'h3, e0);
        push_ev(EV_REQ, 0, 0, e0 + 1);
        push_ev(EV_REQ, 1, 0, e0 + 4);
        drop_start(32'h3);
        wait_until(e0 + 6);
        raise_start(32'h3, e1);
        ack_delay[1] = 2;
        push_ev(EV_ABORT, 0, 0, e1);
        model_frame(32'h3, e1, end_edge, drawn);
        drop_start(32'h3);
        wait_until(e1 + 2);
        check_val("restart_overrun", int'(overrun), 1);
        wait_until(end_edge + 2);
        check_val("restart_clean_overrun", int'(overrun), 0);

        // Mask change after start, then a stray ack in DONE.
        set_delays(2);
        raise_start(32'h3, e0);
        model_frame(32'h3, e0, end_edge, drawn);
        drop_start(32'hF);
        wait_until(end_edge + 2);
        pulse_stray_ack();
        check_val("stray_ack_slots_drawn", int'(slots_drawn), 2);
        check_val("stray_ack_finished",    int'(finished),    1);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NS; i++)
                ack_delay[i] = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 5));
            case ($urandom_range(0, 3))
                0: m = $urandom;
                1: m = $urandom & $urandom & $urandom;
                2: m = 32'h1 << $urandom_range(0, 31);
                default: m = $urandom & $urandom & $urandom & $urandom;
            endcase
            raise_start(m, e0);
            model_frame(m, e0, end_edge, drawn);
            drop_start($urandom);
            wait_until(end_edge + 2);
            if (f % 4 == 0) begin
                pulse_stray_ack();
                check_val("rand_stray_slots_drawn", int'(slots_drawn), drawn);
            end
        end

        repeat (3) @(negedge clk_33m);
        check_val("pending_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
Per-frame controller that sequences the sprite blitter datapath across the RENDER_SLOTS render slots. On each frame start it snapshots which slots are non-empty and issues one blit request per occupied slot in ascending slot order, so later slots overwrite earlier ones. It enforces a cycle budget per frame and reports completion to the game logic. It sits in the clk_33m domain between runner (slot occupancy) and the blitter that writes write_x/write_y/write_palette.

Parameters:
RENDER_SLOTS, 32, number of sprite slots scheduled per frame
SLOT_W, $clog2(RENDER_SLOTS), width of slot index
BUDGET, 500000, max clk_33m cycles from frame start to completion before abort
BUDGET_W, $clog2(BUDGET+1), width of budget counter

Ports:
clk_33m  input  1  33 MHz system clock
reset_n  input  1  asynchronous active-low reset
frame_start  input  1  level from screen reset; rising edge starts a frame
slot_valid  input  RENDER_SLOTS  bit i = slot i non-empty (sprite width != 0)
blit_req  output  1  request blitter to draw blit_slot
blit_slot  output  SLOT_W  slot index being drawn; stable while blit_req=1
blit_ack  input  1  one-cycle pulse: blitter finished current slot
blit_abort  output  1  one-cycle pulse: cancel in-flight blit
busy  output  1  frame in progress
finished  output  1  frame done; held until next frame start
overrun  output  1  last frame was aborted (budget or restart); held until next frame completes cleanly
slots_drawn  output  SLOT_W+1  blits acknowledged in current/last frame

Behaviour:
- Reset (reset_n=0, async): state IDLE; blit_req=0, blit_slot=0, blit_abort=0, busy=0, finished=0, overrun=0, slots_drawn=0, snapshot=0, budget counter=0, frame_start edge register=0.
- Edge detect: fs_q registered copy of frame_start; start = frame_start & ~fs_q.
- States: IDLE, PICK, WAIT_ACK, DONE.
- IDLE/DONE + start: snapshot<=slot_valid, slots_drawn<=0, budget<=0, finished<=0, busy<=1, -> PICK.
- PICK (1 cycle): pick lowest set bit of snapshot. If found: blit_slot<=index, blit_req<=1, clear bit in snapshot, -> WAIT_ACK. If snapshot==0: busy<=0, finished<=1, overrun<=0, -> DONE.
- WAIT_ACK: blit_req held high, blit_slot stable. On blit_ack: blit_req<=0, slots_drawn++, -> PICK. Minimum gap between consecutive requests: one idle cycle (req low) for PICK.
- blit_ack outside WAIT_ACK: ignored, no count.
- Budget: counter increments every cycle while busy; when it reaches BUDGET-1 and state != DONE: blit_req<=0, blit_abort<=1 for one cycle if blit_req was 1, overrun<=1, finished<=1, busy<=0, -> DONE. Ack arriving in the same cycle as expiry: abort wins, ack not counted.
- start while busy: blit_abort pulse if blit_req=1, overrun<=1, then same as start from IDLE (new snapshot, counter cleared), -> PICK next cycle.
- Empty frame (slot_valid=0): finished rises 2 cycles after frame_start edge (edge reg + PICK), slots_drawn=0.
- slot_valid changes mid-frame: no effect; only snapshot used.
- slots_drawn saturates never needed (max RENDER_SLOTS fits SLOT_W+1).
- All outputs registered; no combinational path input->output.

Decomposition:
- runner_pkg: RENDER_SLOTS constant (shared with runner/painter), sched_state_t enum {IDLE, PICK, WAIT_ACK, DONE}.
- Sub-module slot_picker: combinational lowest-set-bit priority encoder, inputs mask[RENDER_SLOTS], outputs found and index[SLOT_W].

Test Plan:
- Reset: hold reset_n=0 mid-WAIT_ACK -> all outputs 0 immediately, state IDLE after release.
- slot_valid=32'h0000_0000, frame_start rise -> finished=1 two cycles later, slots_drawn=0, blit_req never asserted.
- slot_valid=32'h8000_0015, ack 3 cycles after each req -> blit_slot sequence 0,2,4,31; slots_drawn=4; finished=1; overrun=0.
- BUDGET=20, slot_valid=32'h1, blit_ack never -> at cycle 20 after start blit_abort pulse, blit_req=0, overrun=1, finished=1, slots_drawn=0.
- slot_valid=32'h3, second frame_start rise while waiting on slot 1 -> blit_abort pulse, overrun=1, new frame redraws slots 0,1; clean finish clears overrun to 0.
- Change slot_valid from 32'h3 to 32'hF after start -> only slots 0,1 drawn; stray blit_ack in DONE does not change slots_drawn.
